// File: rtl/aes_round_sched_if.sv
// Control bundle between the AES round sequencer and the cipher top / key generator / datapath.
// Names carry i_/o_ from the sequencer's point of view; slave = sequencer side.
interface aes_round_sched_if #(
    parameter int RW = 4
);
    logic          i_start;
    logic          i_abort;
    logic          i_key_valid;
    logic          o_ready;
    logic          o_busy;
    logic          o_key_load;
    logic          o_key_req;
    logic          o_state_load;
    logic          o_state_en;
    logic          o_mix_en;
    logic [RW-1:0] o_round;
    logic          o_done;
    logic          o_err;

    modport slave (
        input  i_start, i_abort, i_key_valid,
        output o_ready, o_busy, o_key_load, o_key_req, o_state_load,
               o_state_en, o_mix_en, o_round, o_done, o_err
    );

    modport master (
        output i_start, i_abort, i_key_valid,
        input  o_ready, o_busy, o_key_load, o_key_req, o_state_load,
               o_state_en, o_mix_en, o_round, o_done, o_err
    );
endinterface

// File: rtl/aes_round_sched.sv
// AES-128 block sequencer: load, then per round wait for key and step datapath; done 2*NR+2 cycles after start at best.
// Stalls in KEYWAIT until key_valid (bounded by TIMEOUT); start accepted only when ready, abort returns to IDLE.
module aes_round_sched #(
    parameter int NR      = 10,
    parameter int RW      = 4,
    parameter int TIMEOUT = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    aes_round_sched_if.slave  sif
);
    localparam int            TW       = $clog2(TIMEOUT);
    localparam logic [RW-1:0] NR_V     = RW'(NR);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KEYWAIT,
        S_ROUND,
        S_DONE,
        S_ERR
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [RW-1:0] r_round, w_round_nxt;
    logic [TW-1:0] r_tmo,   w_tmo_nxt;
    logic          r_err,   w_err_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_round <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_tmo_nxt   = r_tmo;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (sif.i_start) begin
                    w_state_nxt = S_LOAD;
                    w_round_nxt = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_KEYWAIT;
                w_round_nxt = RW'(1);
                w_tmo_nxt   = '0;
            end
            S_KEYWAIT: begin
                // A key arriving on the last allowed cycle still counts.
                if (sif.i_key_valid) begin
                    w_state_nxt = S_ROUND;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            S_ROUND: begin
                if (r_round == NR_V) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_KEYWAIT;
                    w_round_nxt = r_round + RW'(1);
                    w_tmo_nxt   = '0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_round_nxt = '0;
            end
            S_ERR: begin
                w_state_nxt = S_IDLE;
                w_round_nxt = '0;
                w_err_nxt   = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_round_nxt = '0;
            end
        endcase
        // Abort overrides everything, including a pending error flag update.
        if (r_state != S_IDLE && sif.i_abort) begin
            w_state_nxt = S_IDLE;
            w_round_nxt = '0;
            w_err_nxt   = r_err;
        end
    end

    assign sif.o_ready      = (r_state == S_IDLE);
    assign sif.o_busy       = (r_state != S_IDLE);
    assign sif.o_key_load   = (r_state == S_LOAD);
    assign sif.o_state_load = (r_state == S_LOAD);
    assign sif.o_key_req    = (r_state == S_KEYWAIT);
    assign sif.o_state_en   = (r_state == S_ROUND);
    assign sif.o_mix_en     = (r_state == S_ROUND) && (r_round != NR_V);
    assign sif.o_round      = r_round;
    assign sif.o_done       = (r_state == S_DONE);
    assign sif.o_err        = r_err;
endmodule
